tff_bank: RTL and testbench

Parametrised bank of T flip-flops generalising the single-bit toggle flop to WIDTH bits with four operating modes: per-bit toggle, binary count up, binary count down and parallel load. It sits wherever the design currently instantiates discrete toggle flops or small counters, and adds terminal-count and change-indication outputs. All state is on one clock with synchronous active-high reset.

---
 rtl/tff_bank.sv | 89 ++++++++
 tb/tb_tff_bank.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_bank.sv
// tff_bank: WIDTH-bit bank of T flip-flops with toggle, count up/down and
// parallel load modes, plus registered terminal-count and change flags.
//
// Parameters
//   WIDTH   : number of flop bits (1..32)
//   SAT     : count boundary behaviour, 0 = wrap, 1 = saturate
//   RST_VAL : value q takes on reset
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, highest priority
//   en   : operation enable, 0 holds q
//   mode : 00 toggle, 01 count up, 10 count down, 11 load
//   t    : toggle mask (toggle) or load data (load); unused when counting
//   q    : flop bank state
//   tc   : registered terminal-count flag, aligned with q
//   chg  : registered flag, high when q changed on the last edge
module tff_bank #(
    parameter int unsigned      WIDTH   = 8,
    parameter bit               SAT     = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             chg
);

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;

    logic [WIDTH-1:0] q_next_c;
    logic             tc_next_c;

    // Next-state and terminal-count decode; defaults describe the hold case.
    always_comb begin
        q_next_c  = q;
        tc_next_c = 1'b0;
        if (en) begin
            case (mode)
                MODE_TOGGLE: begin
                    q_next_c = q ^ t;
                end
                MODE_UP: begin
                    if (q == ALL_ONES) begin
                        // Boundary: wrap to zero or stay pinned at all ones.
                        tc_next_c = 1'b1;
                        q_next_c  = SAT ? ALL_ONES : ALL_ZERO;
                    end else begin
                        q_next_c = q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (q == ALL_ZERO) begin
                        // Boundary: wrap to all ones or stay pinned at zero.
                        tc_next_c = 1'b1;
                        q_next_c  = SAT ? ALL_ZERO : ALL_ONES;
                    end else begin
                        q_next_c = q - WIDTH'(1);
                    end
                end
                default: begin
                    q_next_c = t;
                end
            endcase
        end
    end

    // State and flag registers; chg compares against the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= RST_VAL;
            tc  <= 1'b0;
            chg <= 1'b0;
        end else begin
            q   <= q_next_c;
            tc  <= tc_next_c;
            chg <= (q_next_c != q);
        end
    end

endmodule

// File: tb/tb_tff_bank.sv
// Bench for tff_bank: two WIDTH=4, RST_VAL=4'hA instances (wrap and
// saturate) share stimulus and are compared against a behavioural model.
module tb_tff_bank;

    localparam logic [1:0] M_TOG  = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] t;

    logic [3:0] q0, q1;
    logic       tc0, tc1, chg0, chg1;

    int errors = 0;
    int checks = 0;

    // Model state, index 0 = wrap instance, 1 = saturate instance.
    int mq   [2];
    bit mtc  [2];
    bit mchg [2];

    tff_bank #(.WIDTH(4), .SAT(1'b0), .RST_VAL(4'hA)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t),
        .q(q0), .tc(tc0), .chg(chg0)
    );

    tff_bank #(.WIDTH(4), .SAT(1'b1), .RST_VAL(4'hA)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t),
        .q(q1), .tc(tc1), .chg(chg1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    wire [11:0] obs = {q0, tc0, chg0, q1, tc1, chg1};

    // Model step from the spec rules using plain integer arithmetic.
    task automatic model_step();
        int nxt;
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                mq[s] = 10; mtc[s] = 1'b0; mchg[s] = 1'b0;
            end else if (!en) begin
                mtc[s] = 1'b0; mchg[s] = 1'b0;
            end else begin
                nxt    = mq[s];
                mtc[s] = 1'b0;
                case (mode)
                    M_TOG:  nxt = mq[s] ^ int'(t);
                    M_UP: begin
                        mtc[s] = (mq[s] + 1 > 15);
                        nxt    = (s == 1) ? ((mq[s] + 1 > 15) ? 15 : mq[s] + 1)
                                          : (mq[s] + 1) % 16;
                    end
                    M_DOWN: begin
                        mtc[s] = (mq[s] - 1 < 0);
                        nxt    = (s == 1) ? ((mq[s] - 1 < 0) ? 0 : mq[s] - 1)
                                          : (mq[s] + 15) % 16;
                    end
                    default: nxt = int'(t);
                endcase
                mchg[s] = (nxt != mq[s]);
                mq[s]   = nxt;
            end
        end
    endtask

    function automatic logic [11:0] exp_vec();
        logic [3:0] a, b;
        a = 4'(mq[0]);
        b = 4'(mq[1]);
        return {a, mtc[0], mchg[0], b, mtc[1], mchg[1]};
    endfunction

    task automatic drv(input logic r, input logic e, input logic [1:0] m, input logic [3:0] tv);
        rst = r; en = e; mode = m; t = tv;
    endtask

    // Wait for the edge, advance the model, return 2 time units after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic test_reset();
        drv(1'b1, 1'b1, M_UP, 4'h0);
        tick();
        tick();
        drv(1'b0, 1'b1, M_UP, 4'h0);
        #4;
        checks++;
        if (obs !== {4'hA, 2'b00, 4'hA, 2'b00}) begin
            errors++; $display("FAIL reset_state: got %h expected %h", obs, {4'hA, 2'b00, 4'hA, 2'b00});
        end
        tick();
        #4;
        checks++;
        if (obs !== exp_vec() || q0 !== 4'hB || q1 !== 4'hB) begin
            errors++; $display("FAIL reset_first_count: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_toggle();
        drv(1'b0, 1'b1, M_LOAD, 4'h0);
        tick();
        drv(1'b0, 1'b1, M_TOG, 4'b0101);
        tick();
        #4;
        checks++;
        if (obs !== exp_vec() || q0 !== 4'h5 || chg0 !== 1'b1) begin
            errors++; $display("FAIL toggle_first: got %h expected %h", obs, exp_vec());
        end
        tick();
        drv(1'b0, 1'b1, M_TOG, 4'h0);
        #4;
        checks++;
        if (obs !== exp_vec() || q0 !== 4'h0 || chg0 !== 1'b1) begin
            errors++; $display("FAIL toggle_second: got %h expected %h", obs, exp_vec());
        end
        tick();
        #4;
        checks++;
        if (obs !== exp_vec() || q0 !== 4'h0 || chg0 !== 1'b0) begin
            errors++; $display("FAIL toggle_zero_mask: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_count_up();
        drv(1'b0, 1'b1, M_LOAD, 4'hE);
        tick();
        drv(1'b0, 1'b1, M_UP, 4'h0);
        tick();
        #4;
        checks++;
        if (obs !== exp_vec() || q0 !== 4'hF || tc0 !== 1'b0) begin
            errors++; $display("FAIL up_to_max: got %h expected %h", obs, exp_vec());
        end
        tick();
        #4;
        checks++;
        if (obs !== exp_vec() || {q0, tc0} !== {4'h0, 1'b1} || {q1, tc1, chg1} !== {4'hF, 2'b10}) begin
            errors++; $display("FAIL up_boundary: got %h expected %h", obs, exp_vec());
        end
        tick();
        #4;
        checks++;
        if (obs !== exp_vec() || {q0, tc0} !== {4'h1, 1'b0} || {q1, tc1} !== {4'hF, 1'b1}) begin
            errors++; $display("FAIL up_after_wrap: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_count_down();
        drv(1'b0, 1'b1, M_LOAD, 4'h1);
        tick();
        drv(1'b0, 1'b1, M_DOWN, 4'h0);
        tick();
        #4;
        checks++;
        if (obs !== exp_vec() || {q1, tc1} !== {4'h0, 1'b0}) begin
            errors++; $display("FAIL down_to_zero: got %h expected %h", obs, exp_vec());
        end
        tick();
        #4;
        checks++;
        if (obs !== exp_vec() || {q1, tc1, chg1} !== {4'h0, 2'b10} || {q0, tc0} !== {4'hF, 1'b1}) begin
            errors++; $display("FAIL down_boundary: got %h expected %h", obs, exp_vec());
        end
        tick();
        #4;
        checks++;
        if (obs !== exp_vec() || {q1, tc1, chg1} !== {4'h0, 2'b10}) begin
            errors++; $display("FAIL down_sat_hold: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_load_hold();
        drv(1'b0, 1'b1, M_LOAD, 4'h7);
        tick();
        tick();
        drv(1'b0, 1'b1, M_LOAD, 4'h3);
        #4;
        checks++;
        if (obs !== exp_vec() || {q0, chg0} !== {4'h7, 1'b0}) begin
            errors++; $display("FAIL load_same: got %h expected %h", obs, exp_vec());
        end
        tick();
        drv(1'b0, 1'b0, M_UP, 4'hF);
        #4;
        checks++;
        if (obs !== exp_vec() || {q0, chg0} !== {4'h3, 1'b1}) begin
            errors++; $display("FAIL load_new: got %h expected %h", obs, exp_vec());
        end
        tick();
        #4;
        checks++;
        if (obs !== exp_vec() || {q0, tc0, chg0, q1, tc1, chg1} !== {4'h3, 2'b00, 4'h3, 2'b00}) begin
            errors++; $display("FAIL enable_low_hold: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_reset_mid_count();
        drv(1'b0, 1'b1, M_LOAD, 4'h5);
        tick();
        drv(1'b0, 1'b1, M_UP, 4'h0);
        tick();
        tick();
        drv(1'b1, 1'b1, M_UP, 4'h0);
        #4;
        checks++;
        if (obs !== exp_vec() || q0 !== 4'h7) begin
            errors++; $display("FAIL mid_count_pre: got %h expected %h", obs, exp_vec());
        end
        tick();
        drv(1'b0, 1'b1, M_UP, 4'h0);
        #4;
        checks++;
        if (obs !== exp_vec() || obs !== {4'hA, 2'b00, 4'hA, 2'b00}) begin
            errors++; $display("FAIL mid_count_reset: got %h expected %h", obs, exp_vec());
        end
    endtask

    // Random back-to-back operations with mode changes every cycle.
    task automatic test_random_back_to_back();
        logic       r, e;
        logic [1:0] m;
        logic [3:0] tv;
        for (int i = 0; i < 400; i++) begin
            tick();
            r  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 3) != 0);
            m  = 2'($urandom_range(0, 3));
            tv = 4'($urandom_range(0, 15));
            drv(r, e, m, tv);
            #4;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            mq[s] = 0; mtc[s] = 1'b0; mchg[s] = 1'b0;
        end
        drv(1'b1, 1'b0, M_TOG, 4'h0);
        test_reset();
        test_toggle();
        test_count_up();
        test_count_down();
        test_load_hold();
        test_reset_mid_count();
        test_random_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
